// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   Periodically reads one channel of an MCP3002 10-bit ADC over SPI
//   (mode 0) and presents each new sample to the processor.
//
//   A free-running sample timer produces a tick every SAMPLE_DIV sysclk
//   cycles. Each tick that finds the FSM idle starts a 16-period SPI frame:
//   SETUP (CS low, first command bit on DIN), SHIFT (32 SCK toggles of
//   CLK_DIV cycles each), DONE (CS high, word published). A tick that
//   lands while a frame is in progress is dropped and latches overrun.
//
//   Optional build macro ADC_SPI_OFFSET_EN: when defined, data_in is the
//   raw code minus 10'h181 (two's-complement about the ADC bias); when
//   undefined, data_in is the raw unsigned code. Timing is the same.
//
// Parameters
//   CLK_DIV    sysclk cycles per SCK half-period (>= 2)
//   SAMPLE_DIV sysclk cycles between frame starts (>= 34*CLK_DIV+4)
//   CHANNEL    MCP3002 ODD/SIGN command bit
//
// Ports
//   sysclk      in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   adc_cs_n    out  ADC chip select, active low
//   adc_sck     out  SPI clock, idles low
//   adc_din     out  command bits to the ADC
//   adc_dout    in   serial data from the ADC
//   data_in     out  10-bit sample word, held between updates
//   data_valid  out  one-cycle pulse with each new data_in (no back-pressure:
//                    the consumer must take the word in the pulse cycle or
//                    read the held data_in before the next pulse)
//   overrun     out  sticky, set by a tick missed because a frame was busy
//   fsm_state   out  debug view of the FSM (0 IDLE, 1 SETUP, 2 SHIFT, 3 DONE)

module adc_spi_reader #(
  parameter int   CLK_DIV    = 25,
  parameter int   SAMPLE_DIV = 5000,
  parameter logic CHANNEL    = 1'b0
) (
  input  logic       sysclk,
  input  logic       rst_n,
  output logic       adc_cs_n,
  output logic       adc_sck,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [9:0] data_in,
  output logic       data_valid,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] DIV_MAX   = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] div_cnt;
  logic [4:0]    tog_cnt;   // SCK toggles completed in SHIFT
  logic [9:0]    shreg;
  logic [9:0]    word;
  logic          tick;
  logic [3:0]    period;
  logic          in_window;

  // Command sequence: start, single-ended, channel, MSB-first, then zeros.
  function automatic logic cmd_bit(input logic [3:0] p);
    case (p)
      4'd0, 4'd1, 4'd3: return 1'b1;
      4'd2:             return CHANNEL;
      default:          return 1'b0;
    endcase
  endfunction

  assign tick      = (timer == TIMER_MAX);
  assign period    = tog_cnt[4:1];
  // Period 4 carries the ADC null bit and period 15 is past the LSB.
  assign in_window = (period >= 4'd5) && (period <= 4'd14);
  assign fsm_state = state;

  always_comb begin
    word = shreg;
`ifdef ADC_SPI_OFFSET_EN
    word = shreg - 10'h181;
`endif
  end

  // Free-running timer keeps frame starts on a fixed grid regardless of FSM.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      adc_cs_n   <= 1'b1;
      adc_sck    <= 1'b0;
      adc_din    <= 1'b0;
      data_in    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      div_cnt    <= '0;
      tog_cnt    <= '0;
      shreg      <= '0;
    end else begin
      data_valid <= 1'b0;
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            adc_sck  <= 1'b0;
            adc_din  <= cmd_bit(4'd0);
            div_cnt  <= '0;
            tog_cnt  <= '0;
            shreg    <= '0;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_MAX) begin
            state   <= SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            adc_sck <= ~adc_sck;
            tog_cnt <= tog_cnt + 5'd1;
            if (!tog_cnt[0]) begin
              // Rising edge: ADC data has been stable since the last fall.
              if (in_window) begin
                shreg <= {shreg[8:0], adc_dout};
              end
            end else if (tog_cnt == 5'd31) begin
              // Sixteenth falling edge ends the frame.
              state      <= DONE;
              adc_cs_n   <= 1'b1;
              adc_din    <= 1'b0;
              data_in    <= word;
              data_valid <= 1'b1;
            end else begin
              // Falling edge: present the bit for the next period.
              adc_din <= cmd_bit(period + 4'd1);
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader. Three instances with CLK_DIV=2:
//   u_a  SAMPLE_DIV=80, CHANNEL=0 : data path, spacing, mid-frame reset
//   u_b  SAMPLE_DIV=80, CHANNEL=1 : command bits and DIN/SCK alignment
//   u_c  SAMPLE_DIV=40            : overrun behaviour
// Expected data values follow ADC_SPI_OFFSET_EN when it is defined.

module tb_adc_spi_reader;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT signals ----------------
  logic rst_a, rst_b, rst_c;
  logic cs_n_a, sck_a, din_a, dout_a, dv_a, ovr_a;
  logic cs_n_b, sck_b, din_b, dv_b, ovr_b;
  logic cs_n_c, sck_c, din_c, dout_c, dv_c, ovr_c;
  logic dout_b = 1'b0;
  logic [9:0] data_a, data_b, data_c;
  logic [1:0] st_a, st_b, st_c;
  logic [9:0] word_a, word_c;

  adc_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(80), .CHANNEL(1'b0)) u_a (
    .sysclk(sysclk), .rst_n(rst_a), .adc_cs_n(cs_n_a), .adc_sck(sck_a),
    .adc_din(din_a), .adc_dout(dout_a), .data_in(data_a), .data_valid(dv_a),
    .overrun(ovr_a), .fsm_state(st_a));

  adc_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(80), .CHANNEL(1'b1)) u_b (
    .sysclk(sysclk), .rst_n(rst_b), .adc_cs_n(cs_n_b), .adc_sck(sck_b),
    .adc_din(din_b), .adc_dout(dout_b), .data_in(data_b), .data_valid(dv_b),
    .overrun(ovr_b), .fsm_state(st_b));

  adc_spi_reader #(.CLK_DIV(2), .SAMPLE_DIV(40), .CHANNEL(1'b0)) u_c (
    .sysclk(sysclk), .rst_n(rst_c), .adc_cs_n(cs_n_c), .adc_sck(sck_c),
    .adc_din(din_c), .adc_dout(dout_c), .data_in(data_c), .data_valid(dv_c),
    .overrun(ovr_c), .fsm_state(st_c));

  // ---------------- ADC models ----------------
  // MCP3002 drives a new bit after each SCK fall; after fall f the bit for
  // period f is on DOUT. Periods 5..14 carry the word MSB first.
  function automatic logic adc_bit(input int p, input logic [9:0] w);
    int k;
    if (p < 5 || p > 14) return 1'b0;
    k = 14 - p;
    return w[k[3:0]];
  endfunction

  int fcnt_a = 0;
  int fcnt_c = 0;
  always @(negedge sck_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      fcnt_a = 0;
      dout_a = 1'b0;
    end else begin
      fcnt_a = fcnt_a + 1;
      dout_a = adc_bit(fcnt_a, word_a);
    end
  end
  always @(negedge sck_c or posedge cs_n_c) begin
    if (cs_n_c) begin
      fcnt_c = 0;
      dout_c = 1'b0;
    end else begin
      fcnt_c = fcnt_c + 1;
      dout_c = adc_bit(fcnt_c, word_c);
    end
  end

  // ---------------- monitors (sampled on falling sysclk) ----------------
  logic prev_cs_a = 1'b1, prev_sck_a = 1'b0, prev_din_a = 1'b0;
  logic prev_cs_b = 1'b1, prev_sck_b = 1'b0, prev_din_b = 1'b0;
  logic [15:0] bits_a = '0, bits_b = '0;
  int rise_a = 0, rise_b = 0, viol_a = 0, viol_b = 0;
  int lowcnt_a = 0, low_len_a = 0, n_dv_a = 0;

  always @(negedge sysclk) begin
    if (!cs_n_a && prev_cs_a) begin
      rise_a <= 0;
      bits_a <= '0;
    end else if (sck_a && !prev_sck_a) begin
      if (rise_a < 16) bits_a[rise_a[3:0]] <= din_a;
      rise_a <= rise_a + 1;
    end
    if (din_a != prev_din_a && sck_a) viol_a <= viol_a + 1;
    if (!cs_n_a) lowcnt_a <= prev_cs_a ? 1 : lowcnt_a + 1;
    if (cs_n_a && !prev_cs_a) low_len_a <= lowcnt_a;
    if (dv_a) n_dv_a <= n_dv_a + 1;
    prev_cs_a  <= cs_n_a;
    prev_sck_a <= sck_a;
    prev_din_a <= din_a;
  end

  always @(negedge sysclk) begin
    if (!cs_n_b && prev_cs_b) begin
      rise_b <= 0;
      bits_b <= '0;
    end else if (sck_b && !prev_sck_b) begin
      if (rise_b < 16) bits_b[rise_b[3:0]] <= din_b;
      rise_b <= rise_b + 1;
    end
    if (din_b != prev_din_b && sck_b) viol_b <= viol_b + 1;
    prev_cs_b  <= cs_n_b;
    prev_sck_b <= sck_b;
    prev_din_b <= din_b;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_dv(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge sysclk);
      if ((which == 0 && dv_a) || (which == 1 && dv_b) || (which == 2 && dv_c)) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_dv%0d: no data_valid within 400 cycles", which);
    end
  endtask

  typedef struct {
    logic [9:0] word;
    logic [9:0] exp_raw;
    logic [9:0] exp_off;
  } vec_t;

  function automatic int exp_of(input logic [9:0] raw_exp, input logic [9:0] off_exp);
`ifdef ADC_SPI_OFFSET_EN
    return int'(off_exp);
`else
    return int'(raw_exp);
`endif
  endfunction

  // ---------------- main sequence ----------------
  vec_t tbl [5];
  int rel, t_now, t_prev, dv_before;
  bit ok;

  initial begin
    tbl[0] = '{10'h2A5, 10'h2A5, 10'h124};
    tbl[1] = '{10'h000, 10'h000, 10'h27F};
    tbl[2] = '{10'h3FF, 10'h3FF, 10'h27E};
    tbl[3] = '{10'h001, 10'h001, 10'h280};
    tbl[4] = '{10'h200, 10'h200, 10'h07F};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    word_a = tbl[0].word;
    word_c = 10'h2A5;
    repeat (3) @(negedge sysclk);

    // Reset state
    check("rst_cs_n", int'(cs_n_a), 1);
    check("rst_sck", int'(sck_a), 0);
    check("rst_din", int'(din_a), 0);
    check("rst_data", int'(data_a), 0);
    check("rst_dv", int'(dv_a), 0);
    check("rst_ovr", int'(ovr_a), 0);
    check("rst_state", int'(st_a), 0);

    // Table: five frames, the later ones back to back on the 80-cycle grid
    rst_a = 1'b1;
    rel = cyc;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_dv(0, ok);
      t_now = cyc;
      check($sformatf("data_%0d", i), int'(data_a), exp_of(tbl[i].exp_raw, tbl[i].exp_off));
      if (i == 0) check("first_latency", t_now - rel, 146);
      else check($sformatf("spacing_%0d", i), t_now - t_prev, 80);
      check($sformatf("cs_done_%0d", i), int'(cs_n_a), 1);
      check($sformatf("sck_done_%0d", i), int'(sck_a), 0);
      check($sformatf("state_done_%0d", i), int'(st_a), 3);
      t_prev = t_now;
      if (i < 4) word_a = tbl[i + 1].word;
      @(negedge sysclk);
      check($sformatf("dv_single_%0d", i), int'(dv_a), 0);
      check($sformatf("data_hold_%0d", i), int'(data_a), exp_of(tbl[i].exp_raw, tbl[i].exp_off));
      check($sformatf("cs_low_len_%0d", i), low_len_a, 66);
    end
    check("din_bits_ch0", int'(bits_a), 16'h000B);
    check("sck_rises_a", rise_a, 16);
    check("ovr_a_clear", int'(ovr_a), 0);

    // Reset during SCK period 8 aborts the frame
    word_a = 10'h15A;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge sysclk);
      if (!cs_n_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("cs_fall_seen", int'(ok), 1);
    repeat (35) @(negedge sysclk);
    dv_before = n_dv_a;
    rst_a = 1'b0;
    #1;
    check("abort_cs_n", int'(cs_n_a), 1);
    check("abort_sck", int'(sck_a), 0);
    check("abort_data", int'(data_a), 0);
    check("abort_state", int'(st_a), 0);
    repeat (3) @(negedge sysclk);
    rst_a = 1'b1;
    rel = cyc;
    wait_dv(0, ok);
    check("post_rst_latency", cyc - rel, 146);
    check("post_rst_data", int'(data_a), exp_of(10'h15A, 10'h3D9));
    @(negedge sysclk);
    check("abort_no_dv", n_dv_a - dv_before, 1);

    // Channel 1 command bits and DIN stability
    rst_b = 1'b1;
    wait_dv(1, ok);
    @(negedge sysclk);
    check("din_bits_ch1", int'(bits_b), 16'h000F);
    check("sck_rises_b", rise_b, 16);
    check("din_viol_b", viol_b, 0);
    check("din_viol_a", viol_a, 0);

    // Overrun with an illegally short sample period
    rst_c = 1'b1;
    rel = cyc;
    repeat (70) @(negedge sysclk);
    check("ovr_before_tick", int'(ovr_c), 0);
    wait_dv(2, ok);
    t_now = cyc;
    check("ovr_latency", t_now - rel, 106);
    check("ovr_data1", int'(data_c), exp_of(10'h2A5, 10'h124));
    check("ovr_set", int'(ovr_c), 1);
    t_prev = t_now;
    wait_dv(2, ok);
    check("ovr_spacing", cyc - t_prev, 80);
    check("ovr_data2", int'(data_c), exp_of(10'h2A5, 10'h124));
    check("ovr_sticky", int'(ovr_c), 1);
    rst_c = 1'b0;
    #1;
    check("ovr_rst_clear", int'(ovr_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
